// File: rtl/ps2_interface.sv
`timescale 1ns/1ps
// PS/2 host controller: filtered receive of device frames plus host-to-device
// command transmit using the inhibit/request-to-send handshake on open-drain lines.
module ps2_interface #(
  parameter int CLK_FREQ_HZ       = 100000000,
  parameter int FILTER_LEN        = 8,
  parameter int INHIBIT_CYCLES    = CLK_FREQ_HZ / 10000,
  parameter int RX_TIMEOUT_CYCLES = CLK_FREQ_HZ / 5000,
  parameter int TX_TIMEOUT_CYCLES = CLK_FREQ_HZ / 500
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  input  logic [7:0] tx_data,
  input  logic       write_data,
  output logic [7:0] rx_data,
  output logic       read_data,
  output logic       busy,
  output logic       err
);

  localparam int TMAX_A = (INHIBIT_CYCLES > RX_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : RX_TIMEOUT_CYCLES;
  localparam int TMAX   = (TMAX_A > TX_TIMEOUT_CYCLES) ? TMAX_A : TX_TIMEOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_DONE_WAIT
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t          state, next_state;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_filt, data_filt, clk_prev;
  logic [FW-1:0]   clk_cnt, data_cnt;
  logic            fall;
  logic            clk_oe, data_oe;
  logic [TW-1:0]   timer;
  logic [3:0]      bit_cnt;
  logic [8:0]      rx_shift;
  logic [8:0]      tx_shift;
  logic [9:0]      frame;
  logic            frame_ok, rx_timeout, tx_timeout;

  // Open-drain: only ever pull low or release.
  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;
  assign fall     = clk_prev & ~clk_filt;

  // Two-flop synchronizers followed by a FILTER_LEN-sample glitch filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_prev  <= 1'b1;
      clk_cnt   <= '0;
      data_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (data_sync[1] == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
        data_filt <= data_sync[1];
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; write_data takes priority over a start edge in IDLE.
  always_comb begin
    next_state = state;
    frame      = {data_filt, rx_shift};
    frame_ok   = frame[9] & (^frame[8:0]);
    rx_timeout = (timer >= TW'(RX_TIMEOUT_CYCLES));
    tx_timeout = (timer >= TW'(TX_TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        if (write_data) next_state = TX_INHIBIT;
        else if (fall && !data_filt) next_state = RX;
        else next_state = IDLE;
      end
      RX: begin
        if (fall && bit_cnt == 4'd9) next_state = IDLE;
        else if (!fall && rx_timeout) next_state = IDLE;
        else next_state = RX;
      end
      TX_INHIBIT: begin
        if (timer >= TW'(INHIBIT_CYCLES - 1)) next_state = TX_REQ;
        else next_state = TX_INHIBIT;
      end
      TX_REQ: next_state = TX_BITS;
      TX_BITS: begin
        if (tx_timeout) next_state = IDLE;
        else if (fall && bit_cnt == 4'd9) next_state = TX_ACK;
        else next_state = TX_BITS;
      end
      TX_ACK: begin
        if (tx_timeout) next_state = IDLE;
        else if (fall && !data_filt) next_state = TX_DONE_WAIT;
        else next_state = TX_ACK;
      end
      TX_DONE_WAIT: begin
        if (tx_timeout) next_state = IDLE;
        else if (clk_filt && data_filt) next_state = IDLE;
        else next_state = TX_DONE_WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: bit shifting, timers, line drive and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      bit_cnt   <= 4'd0;
      rx_shift  <= 9'd0;
      tx_shift  <= 9'd0;
      rx_data   <= 8'h00;
      read_data <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      clk_oe    <= 1'b0;
      data_oe   <= 1'b0;
    end else begin
      read_data <= 1'b0;
      err       <= 1'b0;
      busy      <= (next_state != IDLE);
      clk_oe    <= (next_state == TX_INHIBIT) || (next_state == TX_REQ);
      case (state)
        IDLE: begin
          timer   <= '0;
          bit_cnt <= 4'd0;
          data_oe <= 1'b0;
          if (write_data) tx_shift <= {odd_parity(tx_data), tx_data};
        end
        RX: begin
          data_oe <= 1'b0;
          if (fall) begin
            rx_shift <= frame[9:1];
            bit_cnt  <= bit_cnt + 4'd1;
            timer    <= '0;
            if (bit_cnt == 4'd9) begin
              if (frame_ok) begin
                rx_data   <= frame[7:0];
                read_data <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
            if (rx_timeout) err <= 1'b1;
          end
        end
        TX_INHIBIT: begin
          timer   <= timer + 1'b1;
          data_oe <= (next_state == TX_REQ);
        end
        TX_REQ: begin
          timer   <= '0;
          bit_cnt <= 4'd0;
          data_oe <= 1'b1;
        end
        TX_BITS: begin
          timer <= timer + 1'b1;
          if (tx_timeout) begin
            err     <= 1'b1;
            data_oe <= 1'b0;
          end else if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              data_oe <= 1'b0;
            end else begin
              data_oe  <= ~tx_shift[0];
              tx_shift <= {1'b0, tx_shift[8:1]};
            end
          end
        end
        TX_ACK, TX_DONE_WAIT: begin
          timer   <= timer + 1'b1;
          data_oe <= 1'b0;
          if (tx_timeout) err <= 1'b1;
        end
        default: begin
          timer   <= '0;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_interface.sv
`timescale 1ns/1ps
// Directed bench for ps2_interface: a behavioural PS/2 device drives receive
// frames, answers a host transmit, and exercises glitch, timeout and reset cases.
module tb_ps2_interface;
  localparam int HP  = 40;
  localparam int INH = 300;
  localparam int RXT = 500;
  localparam int TXT = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       write_data = 1'b0;
  logic [7:0] rx_data;
  logic       read_data, busy, err;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int err_cnt = 0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_interface #(
    .CLK_FREQ_HZ(100000000), .FILTER_LEN(8), .INHIBIT_CYCLES(INH),
    .RX_TIMEOUT_CYCLES(RXT), .TX_TIMEOUT_CYCLES(TXT)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tx_data(tx_data), .write_data(write_data), .rx_data(rx_data),
    .read_data(read_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_data === 1'b1) rd_cnt <= rd_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-to-host frame: start, 8 data LSB first, parity, stop; first nbits only.
  task automatic dev_send(input logic [7:0] d, input logic par, input int nbits);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data_low = ~f[i];
      wait_cycles(HP);
      dev_clk_low = 1'b1;
      wait_cycles(HP);
      dev_clk_low = 1'b0;
    end
    wait_cycles(HP);
    dev_data_low = 1'b0;
  endtask

  initial begin
    int r0, e0, n, low;
    logic [9:0] txbits;
    txbits = 10'd0;

    // Reset state
    wait_cycles(5);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_read_data", read_data, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ps2_clk", ps2_clk, 1'b1);
    check("rst_ps2_data", ps2_data, 1'b1);
    rst = 1'b0;
    wait_cycles(20);

    // Valid 0x1C frame
    r0 = rd_cnt; e0 = err_cnt;
    dev_send(8'h1C, 1'b0, 11);
    wait_cycles(20);
    check("rx1c_data", rx_data, 8'h1C);
    check("rx1c_read_pulses", rd_cnt - r0, 1);
    check("rx1c_err", err_cnt - e0, 0);
    check("rx1c_busy", busy, 1'b0);

    // Bad parity
    r0 = rd_cnt; e0 = err_cnt;
    dev_send(8'h1C, 1'b1, 11);
    wait_cycles(20);
    check("par_err_pulses", err_cnt - e0, 1);
    check("par_read_pulses", rd_cnt - r0, 0);
    check("par_rx_data", rx_data, 8'h1C);
    check("par_busy", busy, 1'b0);

    // Host transmit 0xED with a cooperating device
    r0 = rd_cnt; e0 = err_cnt;
    tx_data = 8'hED; write_data = 1'b1;
    wait_cycles(1);
    write_data = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 50) begin wait_cycles(1); n++; end
    low = 0;
    while (ps2_clk === 1'b0 && low < 2000) begin wait_cycles(1); low++; end
    check("tx_inhibit_len_ok", 32'(low >= INH && low < 2000), 1);
    check("tx_start_bit", ps2_data, 1'b0);
    wait_cycles(HP);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      wait_cycles(HP);
      dev_clk_low = 1'b0;
      txbits[i] = ps2_data;
      wait_cycles(HP);
    end
    dev_data_low = 1'b1;
    wait_cycles(HP / 2);
    dev_clk_low = 1'b1;
    wait_cycles(HP);
    dev_clk_low = 1'b0;
    wait_cycles(HP);
    dev_data_low = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin wait_cycles(1); n++; end
    check("tx_data_bits", txbits[7:0], 8'hED);
    check("tx_parity_bit", txbits[8], 1'b1);
    check("tx_stop_bit", txbits[9], 1'b1);
    check("tx_busy_done", busy, 1'b0);
    check("tx_lines_released", {ps2_clk, ps2_data}, 2'b11);
    check("tx_err", err_cnt - e0, 0);
    check("tx_no_read", rd_cnt - r0, 0);
    check("tx_rx_data_kept", rx_data, 8'h1C);

    // Host transmit with a silent device -> timeout
    e0 = err_cnt;
    tx_data = 8'hFF; write_data = 1'b1;
    wait_cycles(1);
    write_data = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 50) begin wait_cycles(1); n++; end
    low = 0;
    while (ps2_clk === 1'b0 && low < 2000) begin wait_cycles(1); low++; end
    n = 0;
    while (err !== 1'b1 && n < TXT + 500) begin wait_cycles(1); n++; end
    check("to_delay_ok", 32'(n >= TXT - 2 && n <= TXT + 2), 1);
    check("to_lines_released", {ps2_clk, ps2_data}, 2'b11);
    check("to_busy", busy, 1'b0);
    wait_cycles(5);
    check("to_err_pulses", err_cnt - e0, 1);

    // 3-cycle clock glitch while idle, then 0xF0
    r0 = rd_cnt; e0 = err_cnt;
    dev_clk_low = 1'b1;
    wait_cycles(3);
    dev_clk_low = 1'b0;
    wait_cycles(5);
    check("glitch_busy_early", busy, 1'b0);
    wait_cycles(30);
    check("glitch_busy", busy, 1'b0);
    check("glitch_err", err_cnt - e0, 0);
    dev_send(8'hF0, 1'b1, 11);
    wait_cycles(20);
    check("rxf0_data", rx_data, 8'hF0);
    check("rxf0_read_pulses", rd_cnt - r0, 1);

    // Reset mid-frame, then 0x29
    r0 = rd_cnt; e0 = err_cnt;
    dev_send(8'h29, 1'b0, 5);
    check("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_read_data", read_data, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err, 1'b0);
    rst = 1'b0;
    wait_cycles(RXT + 100);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_no_read", rd_cnt - r0, 0);
    dev_send(8'h29, 1'b0, 11);
    wait_cycles(20);
    check("rx29_data", rx_data, 8'h29);
    check("rx29_read_pulses", rd_cnt - r0, 1);
    check("rx29_err", err_cnt - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
